mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter B, default 32, SHALL set the data/address width.
REQ-003 Parameter W, default 5, SHALL set the register-index width.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- add_result_in  in  B  branch target from EX/MEM
- alu_result_in  in  B  ALU result / memory address
- r_data2_in  in  B  store data
- mux_RegDst_in  in  W  destination register index
- zero_in  in  1  ALU zero flag
- wb_RegWrite_in  in  1  write-back enable
- wb_MemtoReg_in  in  1  write-back source select
- m_Branch_in  in  1  branch instruction
- m_MemRead_in  in  1  load
- m_MemWrite_in  in  1  store
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write strobe
- dmem_addr  out  B  memory address
- dmem_wdata  out  B  write data
- dmem_rdata  in  B  read data, valid with ack
- dmem_ack  in  1  memory acknowledge
- stall_out  out  1  hold upstream stages
- pc_src_out  out  1  branch taken
- branch_target_out  out  B  branch target
- read_data_out  out  B  to MEM/WB: load data
- alu_result_out  out  B  to MEM/WB: ALU result
- mux_RegDst_out  out  W  to MEM/WB: destination index
- wb_RegWrite_out  out  1  to MEM/WB: write enable
- wb_MemtoReg_out  out  1  to MEM/WB: source select
- misalign_out  out  1  misaligned-access flag

Function
REQ-005 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-006 In IDLE with no memory op, the MEM/WB outputs SHALL register their *_in counterparts at every edge (1-cycle latency); read_data_out SHALL hold its value.
REQ-007 In IDLE with MemRead or MemWrite asserted, stall_out SHALL be 1 combinationally; at the next edge the block SHALL capture address, wdata and we, and SHALL enter REQ.
REQ-008 In REQ, dmem_req SHALL be 1 (registered), dmem_addr/wdata/we SHALL be stable, and stall_out SHALL be 1; when ack is sampled the block SHALL capture dmem_rdata and SHALL enter DONE.
REQ-009 In DONE, stall_out SHALL be 0 and dmem_req SHALL be 0; at the edge the outputs SHALL register the captured data and control, and the FSM SHALL return to IDLE.
REQ-010 Minimum memory-op latency SHALL be 3 cycles (ack in the first REQ cycle); each extra wait cycle SHALL add 1 cycle.
REQ-011 While stall_out=1, wb_RegWrite_out SHALL register 0 (bubble), so write-back never repeats.
REQ-012 When MemRead and MemWrite are both 1, the write SHALL take priority (dmem_we=1).
REQ-013 dmem_ack SHALL be ignored outside REQ.
REQ-014 pc_src_out SHALL equal m_Branch_in AND zero_in (combinational); branch_target_out SHALL equal add_result_in.

Reset
REQ-015 Reset asserted SHALL immediately force IDLE, dmem_req=0, dmem_we=0 and stall_out=0, and SHALL set all registered outputs and misalign_out to 0.
REQ-016 Reset asserted mid-REQ SHALL abandon the access; an ack arriving after reset release SHALL be ignored.

Configuration
REQ-017 With macro MEM_ALIGN_CHECK_EN defined: an op with alu_result_in[1:0]!=0 SHALL NOT issue a request, SHALL stay in IDLE with 1-cycle latency, SHALL pulse misalign_out for one cycle, and SHALL force wb_RegWrite_out=0.
REQ-018 Without MEM_ALIGN_CHECK_EN: misalign_out SHALL be tied 0, and the address SHALL pass through unchecked.

Structure
REQ-019 A shared package pipe_pkg SHALL hold the FSM state encoding and the B/W default constants.
REQ-020 The output register bank SHALL be a sub-module latch_MEM_WB with a bubble input.

Verification
REQ-021 ALU op, RegWrite=1, alu_result_in=0x10 -> next cycle alu_result_out=0x10, wb_RegWrite_out=1, stall_out never 1.
REQ-022 Load from 0x40, ack after 2 REQ cycles, rdata=0xDEADBEEF -> stall_out=1 for 3 cycles, read_data_out=0xDEADBEEF at the edge after DONE.
REQ-023 Store 0x12345678 to 0x80, ack immediate -> dmem_we=1, dmem_wdata=0x12345678 during REQ, wb_RegWrite_out=0.
REQ-024 Branch=1, zero=1, add_result_in=0x100 -> pc_src_out=1, branch_target_out=0x100 in the same cycle.
REQ-025 Reset low during REQ, then ack pulses -> dmem_req=0 immediately, state stays IDLE, no outputs update.
REQ-026 With MEM_ALIGN_CHECK_EN: load at 0x42 -> no dmem_req, misalign_out=1 for one cycle, wb_RegWrite_out=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default data/address and register-index widths,
// and the MEM-stage access FSM state encoding.
package pipe_pkg;

  localparam int unsigned DataWidth   = 32;
  localparam int unsigned RegIdxWidth = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } mem_state_e;

endpackage

// File: rtl/latch_MEM_WB.sv
// MEM/WB pipeline register bank.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset (clears every field)
//   bubble_i         - insert a bubble: write enable registers 0, other fields hold
//   read_data_en_i   - load read_data_i into the read-data field (otherwise it holds)
//   read_data_i .. mem_to_reg_i  - next values for the bank
//   read_data_o .. mem_to_reg_o  - registered outputs toward write-back
module latch_MEM_WB
  import pipe_pkg::*;
#(
  parameter int unsigned B = DataWidth,
  parameter int unsigned W = RegIdxWidth
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble_i,
  input  logic         read_data_en_i,
  input  logic [B-1:0] read_data_i,
  input  logic [B-1:0] alu_result_i,
  input  logic [W-1:0] reg_dst_i,
  input  logic         reg_write_i,
  input  logic         mem_to_reg_i,
  output logic [B-1:0] read_data_o,
  output logic [B-1:0] alu_result_o,
  output logic [W-1:0] reg_dst_o,
  output logic         reg_write_o,
  output logic         mem_to_reg_o
);

  logic [B-1:0] read_data_q;
  logic [B-1:0] alu_result_q;
  logic [W-1:0] reg_dst_q;
  logic         reg_write_q;
  logic         mem_to_reg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      reg_dst_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (bubble_i) begin
      // Only the write enable matters for a bubble; keeping the rest avoids toggling.
      reg_write_q <= 1'b0;
    end else begin
      alu_result_q <= alu_result_i;
      reg_dst_q    <= reg_dst_i;
      reg_write_q  <= reg_write_i;
      mem_to_reg_q <= mem_to_reg_i;
      if (read_data_en_i) begin
        read_data_q <= read_data_i;
      end
    end
  end

  assign read_data_o  = read_data_q;
  assign alu_result_o = alu_result_q;
  assign reg_dst_o    = reg_dst_q;
  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: runs load/store accesses over a req/ack data
// memory port, stalls upstream while an access is in flight, resolves branches,
// and feeds the MEM/WB register bank.
// Optional feature macro: MEM_ALIGN_CHECK_EN - when defined, a memory op with a
// non-word-aligned address is dropped (no request), flagged on misalign_out for
// one cycle and its write-back is suppressed. When undefined misalign_out is 0.
// Ports:
//   clk, reset                    - clock, asynchronous active-low reset
//   add_result_in .. m_MemWrite_in - EX/MEM pipeline inputs
//   dmem_*                        - data memory port (req held until ack)
//   stall_out                     - hold upstream stages
//   pc_src_out, branch_target_out - branch decision and target
//   read_data_out .. wb_MemtoReg_out - MEM/WB registered outputs
//   misalign_out                  - one-cycle misaligned-access flag
module mem_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned B = DataWidth,
  parameter int unsigned W = RegIdxWidth
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] add_result_in,
  input  logic [B-1:0] alu_result_in,
  input  logic [B-1:0] r_data2_in,
  input  logic [W-1:0] mux_RegDst_in,
  input  logic         zero_in,
  input  logic         wb_RegWrite_in,
  input  logic         wb_MemtoReg_in,
  input  logic         m_Branch_in,
  input  logic         m_MemRead_in,
  input  logic         m_MemWrite_in,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [B-1:0] dmem_addr,
  output logic [B-1:0] dmem_wdata,
  input  logic [B-1:0] dmem_rdata,
  input  logic         dmem_ack,
  output logic         stall_out,
  output logic         pc_src_out,
  output logic [B-1:0] branch_target_out,
  output logic [B-1:0] read_data_out,
  output logic [B-1:0] alu_result_out,
  output logic [W-1:0] mux_RegDst_out,
  output logic         wb_RegWrite_out,
  output logic         wb_MemtoReg_out,
  output logic         misalign_out
);

  mem_state_e   state_q;
  logic         req_q;
  logic         we_q;
  logic [B-1:0] addr_q;
  logic [B-1:0] wdata_q;
  logic [B-1:0] rdata_q;
  logic [W-1:0] reg_dst_q;
  logic         reg_write_q;
  logic         mem_to_reg_q;

  logic mem_op;
  logic misaligned;
  logic start;
  logic in_done;

  assign mem_op = m_MemRead_in | m_MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  assign misaligned = alu_result_in[1:0] != 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state_q == StIdle) && mem_op && misaligned;
    end
  end

  assign misalign_out = misalign_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_out = 1'b0;
`endif

  assign start   = (state_q == StIdle) && mem_op && !misaligned;
  assign in_done = (state_q == StDone);

  // Gated by reset so an op presented during reset cannot stall the pipe.
  assign stall_out = reset && (start || (state_q == StReq));

  // Access FSM plus captured request/response; control is captured at issue so
  // DONE does not depend on what upstream presents while it un-stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      reg_dst_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StReq;
            req_q        <= 1'b1;
            we_q         <= m_MemWrite_in;  // write wins when both are set
            addr_q       <= alu_result_in;
            wdata_q      <= r_data2_in;
            reg_dst_q    <= mux_RegDst_in;
            reg_write_q  <= wb_RegWrite_in;
            mem_to_reg_q <= wb_MemtoReg_in;
          end
        end
        StReq: begin
          if (dmem_ack) begin
            state_q <= StDone;
            req_q   <= 1'b0;
            rdata_q <= dmem_rdata;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = req_q && we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  assign pc_src_out        = m_Branch_in & zero_in;
  assign branch_target_out = add_result_in;

  latch_MEM_WB #(
    .B (B),
    .W (W)
  ) u_latch_mem_wb (
    .clk            (clk),
    .reset          (reset),
    .bubble_i       (stall_out),
    .read_data_en_i (in_done),
    .read_data_i    (rdata_q),
    .alu_result_i   (in_done ? addr_q : alu_result_in),
    .reg_dst_i      (in_done ? reg_dst_q : mux_RegDst_in),
    .reg_write_i    (in_done ? reg_write_q : (wb_RegWrite_in && !misaligned)),
    .mem_to_reg_i   (in_done ? mem_to_reg_q : wb_MemtoReg_in),
    .read_data_o    (read_data_out),
    .alu_result_o   (alu_result_out),
    .reg_dst_o      (mux_RegDst_out),
    .reg_write_o    (wb_RegWrite_out),
    .mem_to_reg_o   (wb_MemtoReg_out)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: the bench plays the data memory and
// keeps the expected MEM/WB contents as plain variables updated per instruction.
module tb_mem_stage_ctrl;

  localparam int unsigned B = 32;
  localparam int unsigned W = 5;

  logic         clk;
  logic         reset;
  logic [B-1:0] add_result_in;
  logic [B-1:0] alu_result_in;
  logic [B-1:0] r_data2_in;
  logic [W-1:0] mux_RegDst_in;
  logic         zero_in;
  logic         wb_RegWrite_in;
  logic         wb_MemtoReg_in;
  logic         m_Branch_in;
  logic         m_MemRead_in;
  logic         m_MemWrite_in;
  logic         dmem_req;
  logic         dmem_we;
  logic [B-1:0] dmem_addr;
  logic [B-1:0] dmem_wdata;
  logic [B-1:0] dmem_rdata;
  logic         dmem_ack;
  logic         stall_out;
  logic         pc_src_out;
  logic [B-1:0] branch_target_out;
  logic [B-1:0] read_data_out;
  logic [B-1:0] alu_result_out;
  logic [W-1:0] mux_RegDst_out;
  logic         wb_RegWrite_out;
  logic         wb_MemtoReg_out;
  logic         misalign_out;

  int checks   = 0;
  int failures = 0;

  // Expected MEM/WB contents.
  logic [B-1:0] exp_rd  = '0;
  logic [B-1:0] exp_alu = '0;
  logic [W-1:0] exp_idx = '0;
  logic         exp_rw  = 1'b0;
  logic         exp_m2r = 1'b0;

  mem_stage_ctrl #(
    .B (B),
    .W (W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .add_result_in     (add_result_in),
    .alu_result_in     (alu_result_in),
    .r_data2_in        (r_data2_in),
    .mux_RegDst_in     (mux_RegDst_in),
    .zero_in           (zero_in),
    .wb_RegWrite_in    (wb_RegWrite_in),
    .wb_MemtoReg_in    (wb_MemtoReg_in),
    .m_Branch_in       (m_Branch_in),
    .m_MemRead_in      (m_MemRead_in),
    .m_MemWrite_in     (m_MemWrite_in),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .stall_out         (stall_out),
    .pc_src_out        (pc_src_out),
    .branch_target_out (branch_target_out),
    .read_data_out     (read_data_out),
    .alu_result_out    (alu_result_out),
    .mux_RegDst_out    (mux_RegDst_out),
    .wb_RegWrite_out   (wb_RegWrite_out),
    .wb_MemtoReg_out   (wb_MemtoReg_out),
    .misalign_out      (misalign_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic clear_inputs();
    add_result_in  = '0;
    alu_result_in  = '0;
    r_data2_in     = '0;
    mux_RegDst_in  = '0;
    zero_in        = 1'b0;
    wb_RegWrite_in = 1'b0;
    wb_MemtoReg_in = 1'b0;
    m_Branch_in    = 1'b0;
    m_MemRead_in   = 1'b0;
    m_MemWrite_in  = 1'b0;
    dmem_rdata     = '0;
    dmem_ack       = 1'b0;
  endtask

  // Reset with a memory op presented: nothing may stall or issue.
  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    m_MemRead_in   = 1'b1;
    m_MemWrite_in  = 1'b1;
    alu_result_in  = 32'h0000_0040;
    wb_RegWrite_in = 1'b1;
    dmem_ack       = 1'b1;
    #12;
    checks++;
    if ({dmem_req, dmem_we, stall_out, misalign_out} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: req/we/stall/misalign=%b want 0000",
               {dmem_req, dmem_we, stall_out, misalign_out});
    end
    checks++;
    if ({read_data_out, alu_result_out, mux_RegDst_out, wb_RegWrite_out, wb_MemtoReg_out}
        !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%h alu=%h idx=%h rw=%b m2r=%b want all 0",
               read_data_out, alu_result_out, mux_RegDst_out, wb_RegWrite_out,
               wb_MemtoReg_out);
    end
    #6;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        m_Branch_in   = 1'b1;
        zero_in       = 1'b1;
        add_result_in = 32'h0000_0100;
      end else begin
        m_Branch_in   = 1'($urandom);
        zero_in       = 1'($urandom);
        add_result_in = $urandom;
      end
      #1;
      checks++;
      if ({pc_src_out, branch_target_out} !== {m_Branch_in & zero_in, add_result_in}) begin
        failures++;
        $display("FAIL branch: pc_src=%b target=%h want pc_src=%b target=%h",
                 pc_src_out, branch_target_out, m_Branch_in & zero_in, add_result_in);
      end
    end
    exp_alu = '0; exp_idx = '0; exp_rw = 1'b0; exp_m2r = 1'b0;
  endtask

  // One non-memory instruction: no stall, 1-cycle pass-through, read data holds.
  task automatic test_alu_op(input logic [B-1:0] alu, input logic [W-1:0] idx,
                             input logic rw, input logic m2r);
    m_MemRead_in   = 1'b0;
    m_MemWrite_in  = 1'b0;
    alu_result_in  = alu;
    mux_RegDst_in  = idx;
    wb_RegWrite_in = rw;
    wb_MemtoReg_in = m2r;
    r_data2_in     = $urandom;
    m_Branch_in    = 1'($urandom);
    zero_in        = 1'($urandom);
    add_result_in  = $urandom;
    dmem_ack       = 1'($urandom);  // must be ignored outside REQ
    dmem_rdata     = $urandom;
    @(negedge clk);
    checks++;
    if ({stall_out, dmem_req} !== 2'b00) begin
      failures++;
      $display("FAIL alu_no_stall: stall=%b req=%b want 0 0", stall_out, dmem_req);
    end
    checks++;
    if ({pc_src_out, branch_target_out} !== {m_Branch_in & zero_in, add_result_in}) begin
      failures++;
      $display("FAIL alu_branch: pc_src=%b target=%h want %b %h", pc_src_out,
               branch_target_out, m_Branch_in & zero_in, add_result_in);
    end
    @(posedge clk); #1;
    exp_alu = alu; exp_idx = idx; exp_rw = rw; exp_m2r = m2r;
    checks++;
    if ({read_data_out, alu_result_out, mux_RegDst_out, wb_RegWrite_out, wb_MemtoReg_out}
        !== {exp_rd, exp_alu, exp_idx, exp_rw, exp_m2r}) begin
      failures++;
      $display("FAIL alu_wb: rd=%h alu=%h idx=%h rw=%b m2r=%b want %h %h %h %b %b",
               read_data_out, alu_result_out, mux_RegDst_out, wb_RegWrite_out,
               wb_MemtoReg_out, exp_rd, exp_alu, exp_idx, exp_rw, exp_m2r);
    end
    checks++;
    if (misalign_out !== 1'b0) begin
      failures++;
      $display("FAIL alu_misalign: got %b want 0", misalign_out);
    end
  endtask

  // One load/store; the bench acks after `waits` extra REQ cycles.
  task automatic test_mem_op(input logic ld, input logic st, input logic [B-1:0] addr,
                             input logic [B-1:0] wd, input logic [B-1:0] rdat,
                             input int waits, input logic rw, input logic [W-1:0] idx,
                             input logic m2r);
    int stalls;
    stalls         = 0;
    m_MemRead_in   = ld;
    m_MemWrite_in  = st;
    alu_result_in  = addr;
    r_data2_in     = wd;
    wb_RegWrite_in = rw;
    mux_RegDst_in  = idx;
    wb_MemtoReg_in = m2r;
    m_Branch_in    = 1'($urandom);
    zero_in        = 1'($urandom);
    add_result_in  = $urandom;
    dmem_ack       = 1'b1;  // stray ack in IDLE
    dmem_rdata     = ~rdat;
    @(negedge clk);
    if (stall_out === 1'b1) stalls++;
    checks++;
    if (dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL mem_idle_req: got %b want 0", dmem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_RegWrite_out !== 1'b0) begin
      failures++;
      $display("FAIL mem_issue_bubble: wb_RegWrite_out=%b want 0", wb_RegWrite_out);
    end
    for (int i = 0; i <= waits; i++) begin
      dmem_ack   = (i == waits);
      dmem_rdata = (i == waits) ? rdat : B'($urandom);
      @(negedge clk);
      if (stall_out === 1'b1) stalls++;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, st, addr, wd}) begin
        failures++;
        $display("FAIL mem_req_bus: req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                 dmem_req, dmem_we, dmem_addr, dmem_wdata, st, addr, wd);
      end
      @(posedge clk); #1;
      checks++;
      if (wb_RegWrite_out !== 1'b0) begin
        failures++;
        $display("FAIL mem_req_bubble: wb_RegWrite_out=%b want 0", wb_RegWrite_out);
      end
    end
    dmem_ack   = 1'b1;  // ack in DONE must be ignored
    dmem_rdata = ~rdat;
    @(negedge clk);
    if (stall_out === 1'b1) stalls++;
    checks++;
    if ({dmem_req, dmem_we} !== 2'b00) begin
      failures++;
      $display("FAIL mem_done_req: req=%b we=%b want 0 0", dmem_req, dmem_we);
    end
    checks++;
    if (stalls !== waits + 2) begin
      failures++;
      $display("FAIL mem_stall_cycles: got %0d want %0d", stalls, waits + 2);
    end
    @(posedge clk); #1;
    exp_rd = rdat; exp_alu = addr; exp_idx = idx; exp_rw = rw; exp_m2r = m2r;
    checks++;
    if ({read_data_out, alu_result_out, mux_RegDst_out, wb_RegWrite_out, wb_MemtoReg_out}
        !== {exp_rd, exp_alu, exp_idx, exp_rw, exp_m2r}) begin
      failures++;
      $display("FAIL mem_wb: rd=%h alu=%h idx=%h rw=%b m2r=%b want %h %h %h %b %b",
               read_data_out, alu_result_out, mux_RegDst_out, wb_RegWrite_out,
               wb_MemtoReg_out, exp_rd, exp_alu, exp_idx, exp_rw, exp_m2r);
    end
    m_MemRead_in  = 1'b0;
    m_MemWrite_in = 1'b0;
    dmem_ack      = 1'b0;
  endtask

  task automatic test_random_mix(input int n);
    logic         ld, st, rw, m2r;
    logic [W-1:0] idx;
    logic [B-1:0] a, wd, rdat;
    int           wt;
    for (int k = 0; k < n; k++) begin
      rw  = 1'($urandom);
      m2r = 1'($urandom);
      idx = W'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        test_alu_op(a, idx, rw, m2r);
      end else begin
        st   = 1'($urandom);
        ld   = st ? 1'($urandom) : 1'b1;
        wd   = $urandom;
        rdat = $urandom;
        wt   = $urandom_range(0, 3);
        test_mem_op(ld, st, a & ~32'h3, wd, rdat, wt, st ? 1'b0 : rw, idx, m2r);
      end
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    m_MemRead_in   = 1'b1;
    m_MemWrite_in  = 1'b0;
    alu_result_in  = 32'h0000_0042;
    mux_RegDst_in  = 5'd3;
    wb_RegWrite_in = 1'b1;
    wb_MemtoReg_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_out, dmem_req} !== 2'b00) begin
      failures++;
      $display("FAIL misalign_no_req: stall=%b req=%b want 0 0", stall_out, dmem_req);
    end
    @(posedge clk); #1;
    exp_alu = 32'h0000_0042; exp_idx = 5'd3; exp_rw = 1'b0; exp_m2r = 1'b1;
    checks++;
    if ({misalign_out, wb_RegWrite_out, alu_result_out, read_data_out}
        !== {1'b1, 1'b0, exp_alu, exp_rd}) begin
      failures++;
      $display("FAIL misalign_flag: mis=%b rw=%b alu=%h rd=%h want 1 0 %h %h",
               misalign_out, wb_RegWrite_out, alu_result_out, read_data_out, exp_alu,
               exp_rd);
    end
    // Following ALU op checks that the flag has dropped after one cycle.
    test_alu_op($urandom, W'($urandom), 1'b1, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_req();
    m_MemRead_in   = 1'b1;
    alu_result_in  = 32'h0000_0040;
    wb_RegWrite_in = 1'b1;
    mux_RegDst_in  = 5'd7;
    dmem_ack       = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checks++;
    if (dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_req_pre: dmem_req=%b want 1", dmem_req);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({dmem_req, dmem_we, stall_out, read_data_out, alu_result_out, wb_RegWrite_out}
        !== '0) begin
      failures++;
      $display("FAIL rst_abandon: req=%b we=%b stall=%b rd=%h alu=%h rw=%b want all 0",
               dmem_req, dmem_we, stall_out, read_data_out, alu_result_out,
               wb_RegWrite_out);
    end
    clear_inputs();
    exp_rd = '0; exp_alu = '0; exp_idx = '0; exp_rw = 1'b0; exp_m2r = 1'b0;
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dmem_ack   = 1'b1;
      dmem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({stall_out, dmem_req} !== 2'b00) begin
        failures++;
        $display("FAIL rst_late_ack_ctrl: stall=%b req=%b want 0 0", stall_out, dmem_req);
      end
      @(posedge clk); #1;
      checks++;
      if ({read_data_out, alu_result_out, wb_RegWrite_out} !== {exp_rd, exp_alu, exp_rw})
      begin
        failures++;
        $display("FAIL rst_late_ack_out: rd=%h alu=%h rw=%b want %h %h %b", read_data_out,
                 alu_result_out, wb_RegWrite_out, exp_rd, exp_alu, exp_rw);
      end
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_alu_op(32'h0000_0010, 5'd4, 1'b1, 1'b0);
    test_mem_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 5'd9, 1'b1);
    test_mem_op(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'h0BAD_F00D, 0, 1'b0, 5'd2,
                1'b0);
    // Read and write together: the write strobe must win.
    test_mem_op(1'b1, 1'b1, 32'h0000_00C0, 32'hCAFE_0001, 32'h5555_AAAA, 2, 1'b0, 5'd1,
                1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`else
    // Without the check a misaligned address is issued unchanged.
    test_mem_op(1'b1, 1'b0, 32'h0000_0042, 32'h0, 32'h0102_0304, 0, 1'b1, 5'd3, 1'b1);
`endif
    test_random_mix(40);
    test_reset_mid_req();
    test_alu_op(32'h0000_0010, 5'd4, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
